beta_fetch_queue: RTL

BETA_FETCH_QUEUE -- requirements
Module: beta_fetch_queue

---
 rtl/beta_fetch_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/beta_fetch_queue.sv
// Beta instruction fetch unit: single-outstanding imem requester feeding a DEPTH-entry prefetch FIFO.
// Optional macro BETA_FETCH_SUPERVISOR_EN treats PC bit 31 as the supervisor bit.
module beta_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h0000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h0000_0008
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     redir_valid,
  input  logic [2:0]               pcsel,
  input  logic [31:0]              c_rel_addr,
  input  logic [31:0]              jt,
  input  logic [31:0]              mem_wait_addr,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [31:0]              ir_out,
  output logic [31:0]              pc_plus4,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ir;
  } entry_t;

  entry_t          q [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     cnt;
  logic [31:0]     fetch_pc, req_pc, target;
  logic            outstanding, drop;
  logic            redir, req_fire, rsp_fire, push, pop;

  function automatic logic [31:0] inc4(input logic [31:0] a);
`ifdef BETA_FETCH_SUPERVISOR_EN
    return {a[31], a[30:0] + 31'd4};
`else
    return a + 32'd4;
`endif
  endfunction

  // pcsel 0 never reaches here as a redirect; 3, 6 and 7 all trap to ILLOP
  always_comb begin
    target = ILLOP_VEC;
`ifdef BETA_FETCH_SUPERVISOR_EN
    target = {1'b1, ILLOP_VEC[30:0]};
    case (pcsel)
      3'd1:    target = {fetch_pc[31], c_rel_addr[30:0]};
      3'd2:    target = {jt[31] & fetch_pc[31], jt[30:0]};
      3'd4:    target = {1'b1, XADR_VEC[30:0]};
      3'd5:    target = mem_wait_addr;
      default: target = {1'b1, ILLOP_VEC[30:0]};
    endcase
`else
    case (pcsel)
      3'd1:    target = c_rel_addr;
      3'd2:    target = jt;
      3'd4:    target = XADR_VEC;
      3'd5:    target = mem_wait_addr;
      default: target = ILLOP_VEC;
    endcase
`endif
  end

  assign redir          = redir_valid & (pcsel != 3'd0);
  assign imem_addr      = fetch_pc;
  assign imem_req_valid = reset_n & ~redir_valid & ~outstanding & (cnt < (AW+1)'(DEPTH));
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_fire       = imem_rsp_valid & outstanding;
  // A pcsel=0 redirect is a no-op, so a response arriving with it is still kept
  assign push           = rsp_fire & ~drop & ~redir;
  assign pop            = ir_valid & ir_ready & ~redir;

  assign count    = cnt;
  assign ir_valid = (cnt != '0);
  assign ir_out   = ir_valid ? q[rd_ptr].ir  : 32'h0;
  assign pc_plus4 = ir_valid ? q[rd_ptr].pc4 : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_VEC;
      req_pc      <= 32'h0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      cnt         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redir) begin
      fetch_pc <= target;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      if (rsp_fire) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else if (outstanding) begin
        drop <= 1'b1;
      end
    end else begin
      if (req_fire) begin
        req_pc      <= fetch_pc;
        fetch_pc    <= inc4(fetch_pc);
        outstanding <= 1'b1;
      end
      if (rsp_fire) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; ir_valid gates everything read from it
  always_ff @(posedge clk) begin
    if (reset_n && push) q[wr_ptr] <= '{pc4: inc4(req_pc), ir: imem_rsp_data};
  end
endmodule
